// File: rtl/rf_dump_unit.sv
// rf_dump_unit: walks the RF read port from FIRST_REG to LAST_REG and streams each value out over valid/ready.
// Optional RF_DUMP_CLEAR_EN: clears each dumped register (except x0) on its handshake.
module rf_dump_unit #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG = 31
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic [4:0]  RF_ADR,
  input  logic [31:0] RF_RS,
  output logic [31:0] OUT_DATA,
  output logic [4:0]  OUT_IDX,
  output logic        OUT_VALID,
  input  logic        OUT_READY
`ifdef RF_DUMP_CLEAR_EN
  ,
  output logic [4:0]  RF_WA,
  output logic [31:0] RF_WD,
  output logic        RF_EN
`endif
);
  if (LAST_REG < FIRST_REG || FIRST_REG < 0 || LAST_REG > 31) begin : g_bad_range
    $error("rf_dump_unit: FIRST_REG/LAST_REG out of range");
  end
  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST = 5'(LAST_REG);
  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;
  state_t state;
  logic [4:0] idx;
  assign RF_ADR = idx;
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      idx <= FIRST;
      OUT_DATA <= '0;
      OUT_IDX <= '0;
      OUT_VALID <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else
      case (state)
        IDLE: if (START) begin
          state <= READ;
          idx <= FIRST;
          BUSY <= 1'b1;
        end
        READ: begin
          OUT_DATA <= RF_RS;
          OUT_IDX <= idx;
          OUT_VALID <= 1'b1;
          state <= SEND;
        end
        SEND: if (OUT_READY) begin
          OUT_VALID <= 1'b0;
          if (idx == LAST) begin
            state <= FIN;
            BUSY <= 1'b0;
            DONE <= 1'b1;
          end else begin
            idx <= idx + 5'd1;
            state <= READ;
          end
        end
        FIN: begin
          DONE <= 1'b0;
          idx <= FIRST;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef RF_DUMP_CLEAR_EN
  // x0 is hardwired in the RF, so it never gets a write strobe
  assign RF_WD = '0;
  assign RF_WA = OUT_IDX;
  assign RF_EN = OUT_VALID & OUT_READY & (OUT_IDX != 5'd0) & ~RST;
`endif
endmodule

// File: tb/tb_rf_dump_unit.sv
// tb_rf_dump_unit: queue-based beat model plus directed tests for rf_dump_unit.
module tb_rf_dump_unit;
  logic CLK = 0, RST = 1, START = 0, OUT_READY = 1, reload = 1;
  logic BUSY, DONE, OUT_VALID;
  logic [4:0] RF_ADR, OUT_IDX;
  logic [31:0] RF_RS, OUT_DATA;
  logic start5 = 0, ready5 = 1, busy5, done5, valid5;
  logic [4:0] adr5, idx5;
  logic [31:0] rs5, data5;
  logic [31:0] rf [32];
  int checks = 0, errors = 0;
`ifdef RF_DUMP_CLEAR_EN
  logic [4:0] RF_WA, wa5;
  logic [31:0] RF_WD, wd5;
  logic RF_EN, en5;
`endif
  always #5 CLK = ~CLK;
  assign RF_RS = rf[RF_ADR];
  assign rs5 = rf[adr5];
  always @(posedge CLK)
    if (reload) for (int i = 0; i < 32; i++) rf[i] <= i == 1 ? 32'hDEADBEEF : i == 31 ? 32'h12345678 : 32'(i * 4);
`ifdef RF_DUMP_CLEAR_EN
    else if (RF_EN) rf[RF_WA] <= RF_WD;
`endif
  rf_dump_unit dut (
    .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE), .RF_ADR(RF_ADR), .RF_RS(RF_RS),
    .OUT_DATA(OUT_DATA), .OUT_IDX(OUT_IDX), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
`ifdef RF_DUMP_CLEAR_EN
    , .RF_WA(RF_WA), .RF_WD(RF_WD), .RF_EN(RF_EN)
`endif
  );
  rf_dump_unit #(.FIRST_REG(5), .LAST_REG(5)) dut5 (
    .CLK(CLK), .RST(RST), .START(start5), .BUSY(busy5), .DONE(done5), .RF_ADR(adr5), .RF_RS(rs5),
    .OUT_DATA(data5), .OUT_IDX(idx5), .OUT_VALID(valid5), .OUT_READY(ready5)
`ifdef RF_DUMP_CLEAR_EN
    , .RF_WA(wa5), .RF_WD(wd5), .RF_EN(en5)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Model: a dump is a queue of register indices; each beat appears one cycle after it is fetched
  logic e_busy = 0, e_done = 0, e_valid = 0;
  logic [4:0] e_adr = 0, e_idx = 0;
  logic [31:0] e_data = 0;
  int q[$];
  bit armed = 0;
  int beats = 0, dones = 0, busy_cyc = 0, ens = 0;
  logic [31:0] seen [32];
  always @(negedge CLK) begin
    if (armed) begin
      chk("busy", 32'(BUSY), 32'(e_busy));
      chk("done", 32'(DONE), 32'(e_done));
      chk("valid", 32'(OUT_VALID), 32'(e_valid));
      chk("rf_adr", 32'(RF_ADR), 32'(e_adr));
      if (e_valid) begin
        chk("out_idx", 32'(OUT_IDX), 32'(e_idx));
        chk("out_data", OUT_DATA, e_data);
      end
`ifdef RF_DUMP_CLEAR_EN
      chk("rf_en", 32'(RF_EN), 32'(e_valid && OUT_READY && e_idx != 0 && !RST));
      if (RF_EN) begin
        chk("rf_wa", 32'(RF_WA), 32'(e_idx));
        ens++;
      end
`endif
      if (DONE) dones++;
      if (BUSY) busy_cyc++;
    end
    if (RST) begin
      e_busy = 0; e_done = 0; e_valid = 0; e_adr = 0; e_idx = 0; e_data = 0;
      q.delete();
    end else if (e_done) begin
      e_done = 0; e_adr = 0;
    end else if (!e_busy) begin
      if (START) begin
        e_busy = 1; e_adr = 0;
        for (int i = 0; i < 32; i++) q.push_back(i);
      end
    end else if (!e_valid) begin
      e_valid = 1; e_idx = 5'(q[0]); e_data = rf[q[0]];
    end else if (OUT_READY) begin
      beats++;
      seen[e_idx] = OUT_DATA;
      void'(q.pop_front());
      e_valid = 0;
      if (q.size() == 0) begin
        e_busy = 0; e_done = 1;
      end else e_adr = 5'(q[0]);
    end
  end
  task automatic pulse_start;
    @(posedge CLK); #1 START = 1;
    @(posedge CLK); #1 START = 0;
  endtask
  task automatic do_reload;
    @(posedge CLK); #1 reload = 1;
    @(posedge CLK); #1 reload = 0;
  endtask
  task automatic wait_done;
    for (int i = 0; i < 300 && DONE !== 1'b1; i++) @(negedge CLK);
    chk("wait_done", 32'(DONE), 32'd1);
    @(posedge CLK);
  endtask
  task automatic wait_read(input logic [4:0] a);
    for (int i = 0; i < 300 && !(BUSY === 1'b1 && OUT_VALID === 1'b0 && RF_ADR === a); i++) @(negedge CLK);
    chk("wait_read", 32'(RF_ADR), 32'(a));
  endtask
  int b0, d0, n0, e0;
  initial begin
    repeat (3) @(posedge CLK);
    #1 RST = 0; reload = 0; armed = 1;
    @(negedge CLK);
    chk("rst_data", OUT_DATA, 32'd0);
    chk("rst_idx", 32'(OUT_IDX), 32'd0);
    chk("rst_adr", 32'(RF_ADR), 32'd0);
    chk("rst5_adr", 32'(adr5), 32'd5);
    // single-register instance
    @(posedge CLK); #1 start5 = 1;
    @(posedge CLK); #1 start5 = 0;
    @(negedge CLK);
    chk("s5_read_busy", 32'(busy5), 32'd1);
    chk("s5_read_valid", 32'(valid5), 32'd0);
    @(negedge CLK);
    chk("s5_valid", 32'(valid5), 32'd1);
    chk("s5_idx", 32'(idx5), 32'd5);
    chk("s5_data", data5, 32'h14);
    @(negedge CLK);
    chk("s5_done", 32'(done5), 32'd1);
    chk("s5_busy", 32'(busy5), 32'd0);
    @(negedge CLK);
    chk("s5_done_off", 32'(done5), 32'd0);
    chk("s5_adr", 32'(adr5), 32'd5);
    // full dump, no backpressure
    b0 = busy_cyc; d0 = dones; n0 = beats;
    pulse_start();
    @(negedge CLK);
    chk("t1_read_valid", 32'(OUT_VALID), 32'd0);
    @(negedge CLK);
    chk("t1_first_valid", 32'(OUT_VALID), 32'd1);
    chk("t1_first_idx", 32'(OUT_IDX), 32'd0);
    wait_done();
    chk("t1_busy_cycles", 32'(busy_cyc - b0), 32'd64);
    chk("t1_beats", 32'(beats - n0), 32'd32);
    chk("t1_dones", 32'(dones - d0), 32'd1);
    chk("t1_x1", seen[1], 32'hDEADBEEF);
    chk("t1_x31", seen[31], 32'h12345678);
    chk("t1_x7", seen[7], 32'h1C);
    // backpressure on x7
    do_reload();
    b0 = busy_cyc; d0 = dones; n0 = beats;
    pulse_start();
    wait_read(5'd7);
    @(posedge CLK); #1 OUT_READY = 0;
    repeat (5) begin
      @(negedge CLK);
      chk("bp_valid", 32'(OUT_VALID), 32'd1);
      chk("bp_data", OUT_DATA, 32'h1C);
      chk("bp_idx", 32'(OUT_IDX), 32'd7);
    end
    @(posedge CLK); #1 OUT_READY = 1;
    wait_read(5'd8);
    wait_done();
    chk("bp_busy_cycles", 32'(busy_cyc - b0), 32'd69);
    chk("bp_beats", 32'(beats - n0), 32'd32);
    chk("bp_dones", 32'(dones - d0), 32'd1);
    // START mid-dump is ignored
    do_reload();
    d0 = dones; n0 = beats;
    pulse_start();
    wait_read(5'd10);
    pulse_start();
    wait_done();
    repeat (4) @(negedge CLK);
    chk("rs_beats", 32'(beats - n0), 32'd32);
    chk("rs_dones", 32'(dones - d0), 32'd1);
    chk("rs_idle", 32'(BUSY), 32'd0);
    // reset during SEND of x15
    do_reload();
    pulse_start();
    wait_read(5'd15);
    @(posedge CLK); #1 RST = 1;
    @(posedge CLK); #1 RST = 0;
    d0 = dones;
    @(negedge CLK);
    chk("ab_valid", 32'(OUT_VALID), 32'd0);
    chk("ab_busy", 32'(BUSY), 32'd0);
    chk("ab_adr", 32'(RF_ADR), 32'd0);
    repeat (3) @(negedge CLK);
    chk("ab_no_done", 32'(dones - d0), 32'd0);
    pulse_start();
    for (int i = 0; i < 10 && OUT_VALID !== 1'b1; i++) @(negedge CLK);
    chk("ab_restart_idx", 32'(OUT_IDX), 32'd0);
    wait_done();
`ifdef RF_DUMP_CLEAR_EN
    do_reload();
    e0 = ens;
    pulse_start();
    wait_done();
    chk("clr_writes", 32'(ens - e0), 32'd31);
    pulse_start();
    wait_done();
    chk("clr_x1", seen[1], 32'd0);
    chk("clr_x7", seen[7], 32'd0);
    chk("clr_x31", seen[31], 32'd0);
`endif
    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
